// File: rtl/jtkiwi_pkg.sv
// Shared constants and encodings for the object attribute RAM and its copy engine.
package jtkiwi_pkg;
    localparam int          LUT_AW   = 12;
    localparam int          Y_AW     = 9;
    localparam logic [8:0]  Y_LAST   = 9'h1ff;
    localparam logic [11:0] LUT_LAST = 12'hfff;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CPY_Y = 2'd1,
        CPY_L = 2'd2,
        FLUSH = 2'd3
    } copy_st_t;

    // Which RAM the registered CPU read data comes from on this clk
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_Y    = 2'd1,
        SEL_LO   = 2'd2,
        SEL_HI   = 2'd3
    } cpu_sel_t;
endpackage

// File: rtl/jtframe_dual_ram.sv
// Two-port synchronous RAM, registered reads, read-before-write on each port.
module jtframe_dual_ram #(
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data0,
    input  logic [AW-1:0] addr0,
    input  logic          we0,
    output logic [DW-1:0] q0,
    input  logic [DW-1:0] data1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    output logic [DW-1:0] q1
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we0) r_mem[addr0] <= data0;
        if (we1) r_mem[addr1] <= data1;
    end

    // Only the output registers are reset; contents survive reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            q0 <= r_mem[addr0];
            q1 <= r_mem[addr1];
        end
    end
endmodule

// File: rtl/jtkiwi_objram_copy.sv
// Vblank copy engine: walks the Y table then the LUT, writing shadows one clk behind the reads.
module jtkiwi_objram_copy
    import jtkiwi_pkg::*;
#(
    parameter int LUT_AW = 12,
    parameter int Y_AW   = 9
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              vb,
    output logic [LUT_AW-1:0] rd_addr,
    output logic [LUT_AW-1:0] wr_addr,
    output logic              y_we,
    output logic              l_we,
    output logic              busy
);
    copy_st_t          r_st, w_nxt;
    logic [LUT_AW-1:0] r_cnt, r_wr_addr;
    logic              r_vb_l, r_wr_y, r_wr_l;
    logic              w_rise, w_y_end, w_l_end;

    assign w_rise  = vb & ~r_vb_l;
    assign w_y_end = r_cnt[Y_AW-1:0] == {Y_AW{1'b1}};
    assign w_l_end = r_cnt == {LUT_AW{1'b1}};

    // r_vb_l resets high so a vb already high at reset release is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st      <= IDLE;
            r_cnt     <= '0;
            r_vb_l    <= 1'b1;
            r_wr_y    <= 1'b0;
            r_wr_l    <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_st      <= w_nxt;
            r_vb_l    <= vb;
            r_wr_y    <= r_st == CPY_Y;
            r_wr_l    <= r_st == CPY_L;
            r_wr_addr <= r_cnt;
            case (r_st)
                CPY_Y:   r_cnt <= w_y_end ? '0 : r_cnt + 1'b1;
                CPY_L:   r_cnt <= r_cnt + 1'b1;
                default: r_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        w_nxt = r_st;
        case (r_st)
            IDLE:    if (w_rise)  w_nxt = CPY_Y;
            CPY_Y:   if (w_y_end) w_nxt = CPY_L;
            CPY_L:   if (w_l_end) w_nxt = FLUSH;
            default: w_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = r_st != IDLE;
        rd_addr = r_cnt;
        wr_addr = r_wr_addr;
        y_we    = r_wr_y;
        l_we    = r_wr_l;
    end
endmodule

// File: rtl/jtkiwi_objram.sv
// Object attribute RAM: CPU-side Y table and 16-bit LUT, snapshotted to video shadows on vblank.
module jtkiwi_objram
    import jtkiwi_pkg::*;
#(
    parameter int LUT_AW = 12,
    parameter int Y_AW   = 9
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              vb,
    input  logic [LUT_AW:0]   cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_rnw,
    input  logic              yram_cs,
    input  logic              lram_cs,
    output logic [7:0]        cpu_din,
    input  logic [LUT_AW-1:0] lut_addr,
    output logic [15:0]       lut_data,
    input  logic [Y_AW-1:0]   y_addr,
    output logic [7:0]        y_data,
    output logic              copy_busy
);
    cpu_sel_t          r_sel;
    logic [7:0]        r_last;
    logic [LUT_AW-1:0] w_rd, w_wr;
    logic              w_ysh_we, w_lsh_we;
    logic              w_y_we, w_lo_we, w_hi_we, w_l_ok;
    logic [7:0]        w_y_cq, w_lo_cq, w_hi_cq, w_y_cp, w_lo_cp, w_hi_cp;
    logic [7:0]        w_unused_ysh;
    logic [15:0]       w_unused_lsh;

    // yram_cs wins if both selects are asserted
    assign w_l_ok  = lram_cs & ~yram_cs;
    assign w_y_we  = yram_cs & ~cpu_rnw;
    assign w_lo_we = w_l_ok & ~cpu_rnw & ~cpu_addr[LUT_AW];
    assign w_hi_we = w_l_ok & ~cpu_rnw &  cpu_addr[LUT_AW];

    jtkiwi_objram_copy #(.LUT_AW(LUT_AW), .Y_AW(Y_AW)) u_copy (
        .rst     (rst),
        .clk     (clk),
        .vb      (vb),
        .rd_addr (w_rd),
        .wr_addr (w_wr),
        .y_we    (w_ysh_we),
        .l_we    (w_lsh_we),
        .busy    (copy_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel  <= SEL_NONE;
            r_last <= '0;
        end else begin
            r_last <= cpu_din;
            if (yram_cs)      r_sel <= SEL_Y;
            else if (lram_cs) r_sel <= cpu_addr[LUT_AW] ? SEL_HI : SEL_LO;
            else              r_sel <= SEL_NONE;
        end
    end

    always_comb begin
        case (r_sel)
            SEL_Y:   cpu_din = w_y_cq;
            SEL_LO:  cpu_din = w_lo_cq;
            SEL_HI:  cpu_din = w_hi_cq;
            default: cpu_din = r_last;
        endcase
    end

    // CPU RAMs: port 0 is the CPU, port 1 is the copy engine read
    jtframe_dual_ram #(.DW(8), .AW(Y_AW)) u_ycpu (
        .clk(clk), .rst(rst),
        .data0(cpu_dout), .addr0(cpu_addr[Y_AW-1:0]), .we0(w_y_we), .q0(w_y_cq),
        .data1(8'd0), .addr1(w_rd[Y_AW-1:0]), .we1(1'b0), .q1(w_y_cp)
    );

    jtframe_dual_ram #(.DW(8), .AW(LUT_AW)) u_locpu (
        .clk(clk), .rst(rst),
        .data0(cpu_dout), .addr0(cpu_addr[LUT_AW-1:0]), .we0(w_lo_we), .q0(w_lo_cq),
        .data1(8'd0), .addr1(w_rd), .we1(1'b0), .q1(w_lo_cp)
    );

    jtframe_dual_ram #(.DW(8), .AW(LUT_AW)) u_hicpu (
        .clk(clk), .rst(rst),
        .data0(cpu_dout), .addr0(cpu_addr[LUT_AW-1:0]), .we0(w_hi_we), .q0(w_hi_cq),
        .data1(8'd0), .addr1(w_rd), .we1(1'b0), .q1(w_hi_cp)
    );

    // Shadows: port 0 is the copy write, port 1 is the scanner read
    jtframe_dual_ram #(.DW(8), .AW(Y_AW)) u_ysh (
        .clk(clk), .rst(rst),
        .data0(w_y_cp), .addr0(w_wr[Y_AW-1:0]), .we0(w_ysh_we), .q0(w_unused_ysh),
        .data1(8'd0), .addr1(y_addr), .we1(1'b0), .q1(y_data)
    );

    jtframe_dual_ram #(.DW(16), .AW(LUT_AW)) u_lsh (
        .clk(clk), .rst(rst),
        .data0({w_hi_cp, w_lo_cp}), .addr0(w_wr), .we0(w_lsh_we), .q0(w_unused_lsh),
        .data1(16'd0), .addr1(lut_addr), .we1(1'b0), .q1(lut_data)
    );
endmodule

// File: tb/tb_jtkiwi_objram.sv
// Scoreboard bench for jtkiwi_objram: CPU access, vblank snapshot timing and boundary cases.
module tb_jtkiwi_objram;
    logic        rst, clk, vb;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_dout, cpu_din, y_data;
    logic        cpu_rnw, yram_cs, lram_cs, copy_busy;
    logic [11:0] lut_addr;
    logic [15:0] lut_data;
    logic [8:0]  y_addr;

    jtkiwi_objram dut (
        .rst(rst), .clk(clk), .vb(vb),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
        .yram_cs(yram_cs), .lram_cs(lram_cs), .cpu_din(cpu_din),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .y_addr(y_addr), .y_data(y_data), .copy_busy(copy_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;   // 0 cpu_din, 1 y_data, 2 lut_data
        logic [15:0] exp;
    } sb_t;

    sb_t        sbq[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_y [512];
    logic [7:0] m_lo[4096];
    logic [7:0] m_hi[4096];
    logic [7:0] s_y [512];
    logic [7:0] s_lo[4096];
    logic [7:0] s_hi[4096];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic pop_chk();
        sb_t         e;
        logic [15:0] got;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            case (e.kind)
                0:       got = {8'd0, cpu_din};
                1:       got = {8'd0, y_data};
                default: got = lut_data;
            endcase
            chk(e.tag, {16'd0, got}, {16'd0, e.exp});
        end
    endtask

    task automatic cpu_wr(input logic ysel, input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        yram_cs = ysel; lram_cs = ~ysel; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
        if (ysel)      m_y[a[8:0]]   = d;
        else if (a[12]) m_hi[a[11:0]] = d;
        else           m_lo[a[11:0]] = d;
        @(negedge clk);
        yram_cs = 1'b0; lram_cs = 1'b0; cpu_rnw = 1'b1;
    endtask

    task automatic cpu_rd(input string tag, input logic ysel, input logic [12:0] a);
        sb_t e;
        @(negedge clk);
        yram_cs = ysel; lram_cs = ~ysel; cpu_rnw = 1'b1; cpu_addr = a;
        e.tag = tag; e.kind = 0;
        e.exp = {8'd0, ysel ? m_y[a[8:0]] : (a[12] ? m_hi[a[11:0]] : m_lo[a[11:0]])};
        sbq.push_back(e);
        @(posedge clk); #1;
        pop_chk();
        @(negedge clk);
        yram_cs = 1'b0; lram_cs = 1'b0;
        // No select: the last read value must be held
        e.tag = {tag, "_hold"};
        sbq.push_back(e);
        @(posedge clk); #1;
        pop_chk();
    endtask

    task automatic vid_rd(input string tag, input logic is_y, input logic [11:0] a);
        sb_t e;
        @(negedge clk);
        e.tag = tag;
        if (is_y) begin
            y_addr = a[8:0]; e.kind = 1; e.exp = {8'd0, s_y[a[8:0]]};
        end else begin
            lut_addr = a; e.kind = 2; e.exp = {s_hi[a], s_lo[a]};
        end
        sbq.push_back(e);
        @(posedge clk); #1;
        pop_chk();
    endtask

    // kind: 0 plain, 1 second vb pulse at clk 100, 2 write Y[0x10] at clk 100, 3 reset at clk 2000
    task automatic run_copy(input int kind);
        logic [7:0] n_y[512];
        logic [7:0] n_lo[4096];
        logic [7:0] n_hi[4096];
        int  n;
        bit  done;
        @(negedge clk);
        vb = 1'b1;
        for (int i = 0; i < 512; i++)  n_y[i] = m_y[i];
        for (int i = 0; i < 4096; i++) begin n_lo[i] = m_lo[i]; n_hi[i] = m_hi[i]; end
        @(posedge clk); #1;
        chk("busy_rise", {31'd0, copy_busy}, 32'd1);
        n = 1; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (n == 10 && kind != 3) vb = 1'b0;
            if (kind == 1 && n == 100) vb = 1'b1;
            if (kind == 1 && n == 110) vb = 1'b0;
            if (kind == 2 && n == 100) begin
                yram_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 13'h010; cpu_dout = 8'h11;
                m_y[9'h010] = 8'h11;
            end
            if (kind == 2 && n == 101) begin yram_cs = 1'b0; cpu_rnw = 1'b1; end
            if (kind == 3 && n == 2000) begin
                rst = 1'b1; #1;
                chk("rst_busy", {31'd0, copy_busy}, 32'd0);
                return;
            end
            @(posedge clk); #1;
            if (copy_busy) n++;
            else done = 1'b1;
            if (n > 6000) done = 1'b1;
        end
        chk("busy_len", n, 32'd4609);
        for (int i = 0; i < 512; i++)  s_y[i] = n_y[i];
        for (int i = 0; i < 4096; i++) begin s_lo[i] = n_lo[i]; s_hi[i] = n_hi[i]; end
    endtask

    initial begin
        rst = 1'b1; vb = 1'b0; cpu_addr = '0; cpu_dout = '0; cpu_rnw = 1'b1;
        yram_cs = 1'b0; lram_cs = 1'b0; lut_addr = '0; y_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_din",  {24'd0, cpu_din},   32'd0);
        chk("rst_y_data",   {24'd0, y_data},    32'd0);
        chk("rst_lut_data", {16'd0, lut_data},  32'd0);
        chk("rst_busy",     {31'd0, copy_busy}, 32'd0);
        @(negedge clk); rst = 1'b0;

        cpu_wr(1'b1, 13'h01a, 8'h5c);
        cpu_rd("cpu_y1a", 1'b1, 13'h01a);
        cpu_wr(1'b1, 13'h1ff, 8'h33);
        cpu_wr(1'b1, 13'h010, 8'h22);
        cpu_wr(1'b0, 13'h1003, 8'hab);
        cpu_wr(1'b0, 13'h0003, 8'hcd);
        cpu_rd("cpu_lut_hi", 1'b0, 13'h1003);
        cpu_rd("cpu_lut_lo", 1'b0, 13'h0003);

        run_copy(1);
        vid_rd("vid_y1ff_a", 1'b1, 12'h1ff);
        vid_rd("vid_lut3_a", 1'b0, 12'h003);
        vid_rd("vid_y010_a", 1'b1, 12'h010);

        cpu_wr(1'b1, 13'h1ff, 8'h77);
        vid_rd("vid_y1ff_novb", 1'b1, 12'h1ff);

        run_copy(2);
        vid_rd("vid_y1ff_flush", 1'b1, 12'h1ff);
        vid_rd("vid_y010_old", 1'b1, 12'h010);
        cpu_rd("cpu_y010_new", 1'b1, 13'h010);

        run_copy(0);
        vid_rd("vid_y010_new", 1'b1, 12'h010);

        cpu_wr(1'b0, 13'h0003, 8'h5a);
        run_copy(3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("vb_high_no_copy", {31'd0, copy_busy}, 32'd0);
        @(negedge clk); vb = 1'b0;
        @(negedge clk);
        run_copy(0);
        vid_rd("vid_lut3_b", 1'b0, 12'h003);
        vid_rd("vid_y1ff_b", 1'b1, 12'h1ff);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
